// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter: shares the single-port IMEM between core fetch and the loader/debug port.
// Optional build macro IMEM_LOAD_LOCK_EN adds a lock FSM that holds the core while the loader owns memory.
//
// lock state | meaning
// RUN        | fetch-priority arbitration with loader anti-starvation
// LOCKED     | loader session active; core held, loader always wins
module imem_access_arbiter #(
    parameter int DEPTH      = 49,
    parameter int AW         = 6,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_pc,
    output logic          fetch_gnt,
    output logic          fetch_valid,
    output logic [31:0]   fetch_instr,
    output logic          fetch_err,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [31:0]   ld_rdata,
    input  logic          ld_done,
    output logic          core_hold,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Owner tag records which requester's response is due in the cycle after the grant.
    typedef enum logic [2:0] {
        OWN_NONE,
        OWN_FETCH,
        OWN_FETCH_ERR,
        OWN_LD_RD,
        OWN_LD_NULL
    } owner_t;

    owner_t      owner_q, owner_d;
    logic [3:0]  starve_cnt, starve_d;
    logic [31:0] instr_q, rdata_q;
    logic [29:0] fetch_idx;
    logic        fetch_legal, ld_in_range, locked;

    assign fetch_idx   = fetch_pc[31:2];
    assign fetch_legal = (fetch_pc[1:0] == 2'b00) && (fetch_idx < 30'(DEPTH));
    // Extra bit keeps the compare correct when DEPTH == 2**AW.
    assign ld_in_range = {1'b0, ld_addr} < (AW+1)'(DEPTH);

`ifdef IMEM_LOAD_LOCK_EN
    typedef enum logic {RUN, LOCKED} lock_t;
    lock_t lock_q, lock_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lock_q <= RUN;
        else     lock_q <= lock_d;
    end

    always_comb begin
        lock_d = lock_q;
        case (lock_q)
            RUN:     if (ld_gnt && ld_we) lock_d = LOCKED;
            LOCKED:  if (ld_done && !(ld_gnt && ld_we)) lock_d = RUN;
            default: lock_d = RUN;
        endcase
    end

    assign locked = (lock_q == LOCKED);
`else
    logic unused_ld_done;
    assign unused_ld_done = ld_done;
    assign locked         = 1'b0;
`endif

    assign core_hold = locked;

    // An illegal fetch never beats a waiting loader; it is only answered when alone.
    always_comb begin
        fetch_gnt = 1'b0;
        ld_gnt    = 1'b0;
        if (locked) begin
            ld_gnt = ld_req;
        end else if (fetch_req && ld_req) begin
            if (fetch_legal && (starve_cnt < 4'(STARVE_MAX))) fetch_gnt = 1'b1;
            else                                              ld_gnt    = 1'b1;
        end else begin
            fetch_gnt = fetch_req;
            ld_gnt    = ld_req;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        owner_d   = OWN_NONE;
        if (fetch_gnt) begin
            if (fetch_legal) begin
                mem_en   = 1'b1;
                mem_addr = fetch_pc[AW+1:2];
                owner_d  = OWN_FETCH;
            end else begin
                owner_d  = OWN_FETCH_ERR;
            end
        end else if (ld_gnt) begin
            if (ld_in_range) begin
                mem_en    = 1'b1;
                mem_we    = ld_we;
                mem_addr  = ld_addr;
                mem_wdata = ld_we ? ld_wdata : 32'h0;
            end
            if (!ld_we) owner_d = ld_in_range ? OWN_LD_RD : OWN_LD_NULL;
        end
    end

    always_comb begin
        starve_d = starve_cnt;
        if (ld_gnt || !ld_req)
            starve_d = 4'd0;
        else if (fetch_gnt && fetch_legal && (starve_cnt < 4'(STARVE_MAX)))
            starve_d = starve_cnt + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= OWN_NONE;
            starve_cnt <= 4'd0;
            instr_q    <= NOP;
            rdata_q    <= 32'h0;
        end else begin
            owner_q    <= owner_d;
            starve_cnt <= starve_d;
            if (owner_q == OWN_FETCH)          instr_q <= mem_rdata;
            else if (owner_q == OWN_FETCH_ERR) instr_q <= NOP;
            if (owner_q == OWN_LD_RD)          rdata_q <= mem_rdata;
            else if (owner_q == OWN_LD_NULL)   rdata_q <= 32'h0;
        end
    end

    // Response data passes straight from memory in the valid cycle, then is held.
    assign fetch_valid = (owner_q == OWN_FETCH) || (owner_q == OWN_FETCH_ERR);
    assign fetch_err   = (owner_q == OWN_FETCH_ERR);
    assign fetch_instr = (owner_q == OWN_FETCH)     ? mem_rdata :
                         (owner_q == OWN_FETCH_ERR) ? NOP : instr_q;
    assign ld_rvalid   = (owner_q == OWN_LD_RD) || (owner_q == OWN_LD_NULL);
    assign ld_rdata    = (owner_q == OWN_LD_RD)   ? mem_rdata :
                         (owner_q == OWN_LD_NULL) ? 32'h0 : rdata_q;

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Scoreboard bench for imem_access_arbiter: a reference arbiter/memory model predicts grants and
// pushes expected responses, which are popped and compared in the following cycle.
module tb_imem_access_arbiter;
    localparam int DEPTH = 49;
    localparam int AW    = 6;
    localparam int SMAX  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fetch_req = 1'b0;
    logic [31:0]   fetch_pc = '0;
    logic          fetch_gnt, fetch_valid, fetch_err;
    logic [31:0]   fetch_instr;
    logic          ld_req = 1'b0;
    logic          ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [31:0]   ld_wdata = '0;
    logic          ld_gnt, ld_rvalid;
    logic [31:0]   ld_rdata;
    logic          ld_done = 1'b0;
    logic          core_hold, mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    always #5 clk = ~clk;

    imem_access_arbiter #(.DEPTH(DEPTH), .AW(AW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_err(fetch_err),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_done(ld_done),
        .core_hold(core_hold), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory array attached to the DUT: synchronous 1-cycle read.
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    typedef struct packed {
        logic        fv;
        logic        fe;
        logic [31:0] fi;
        logic        lv;
        logic [31:0] ld;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] ref_mem [0:63];
    int          starve;
    bit          lock_m;
    logic [31:0] exp_instr, exp_rdata;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic fr, input logic [31:0] pc, input logic lr, input logic we,
                        input logic [AW-1:0] a, input logic [31:0] wd, input logic dn);
        rsp_t          r;
        logic          legal, ok_a, eg_f, eg_l, e_en, e_we;
        logic [AW-1:0] e_addr;
        @(posedge clk); #1;
        if (sb.size() > 0) r = sb.pop_front();
        else r = '{fv: 1'b0, fe: 1'b0, fi: exp_instr, lv: 1'b0, ld: exp_rdata};
        check("fetch_valid", 32'(fetch_valid), 32'(r.fv));
        check("fetch_err", 32'(fetch_err), 32'(r.fe));
        check("fetch_instr", fetch_instr, r.fi);
        check("ld_rvalid", 32'(ld_rvalid), 32'(r.lv));
        check("ld_rdata", ld_rdata, r.ld);

        fetch_req = fr; fetch_pc = pc; ld_req = lr; ld_we = we;
        ld_addr = a; ld_wdata = wd; ld_done = dn;
        #1;
        legal = (pc[1:0] == 2'b00) && (pc[31:2] < DEPTH);
        ok_a  = (int'(a) < DEPTH);
        eg_f  = 1'b0;
        eg_l  = 1'b0;
        if (lock_m) eg_l = lr;
        else if (fr && lr) begin
            if (legal && starve < SMAX) eg_f = 1'b1;
            else                        eg_l = 1'b1;
        end else begin
            eg_f = fr;
            eg_l = lr;
        end
        e_en   = (eg_f && legal) || (eg_l && ok_a);
        e_we   = eg_l && ok_a && we;
        e_addr = (eg_f && legal) ? pc[AW+1:2] : ((eg_l && ok_a) ? a : '0);
        check("fetch_gnt", 32'(fetch_gnt), 32'(eg_f));
        check("ld_gnt", 32'(ld_gnt), 32'(eg_l));
        check("mem_en", 32'(mem_en), 32'(e_en));
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_addr", 32'(mem_addr), 32'(e_addr));
        check("core_hold", 32'(core_hold), 32'(lock_m));
        if (e_we) check("mem_wdata", mem_wdata, wd);

        r.fv = eg_f;
        r.fe = eg_f && !legal;
        if (eg_f) exp_instr = legal ? ref_mem[pc[AW+1:2]] : NOP;
        r.fi = exp_instr;
        r.lv = eg_l && !we;
        if (r.lv) exp_rdata = ok_a ? ref_mem[a] : 32'h0;
        r.ld = exp_rdata;
        sb.push_back(r);

        if (e_we) ref_mem[a] = wd;
        if (eg_l || !lr) starve = 0;
        else if (fr && lr && eg_f && starve < SMAX) starve++;
`ifdef IMEM_LOAD_LOCK_EN
        if (eg_l && we) lock_m = 1'b1;
        else if (dn)    lock_m = 1'b0;
`endif
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0, 1'b0);
    endtask

    task automatic done_pulse();
        step(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        starve    = 0;
        lock_m    = 1'b0;
        exp_instr = NOP;
        exp_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_fetch_valid", 32'(fetch_valid), 32'h0);
        check("rst_fetch_err", 32'(fetch_err), 32'h0);
        check("rst_fetch_instr", fetch_instr, NOP);
        check("rst_ld_rvalid", 32'(ld_rvalid), 32'h0);
        check("rst_ld_rdata", ld_rdata, 32'h0);
        check("rst_core_hold", 32'(core_hold), 32'h0);

        // Preload words 0..7 through the loader port.
        for (int i = 0; i < 8; i++)
            step(1'b0, 32'h0, 1'b1, 1'b1, AW'(i), 32'h1111_0000 + 32'(i), 1'b0);
        done_pulse();

        // Back-to-back legal fetches.
        step(1'b1, 32'd0, 1'b0, 1'b0, '0, 32'h0, 1'b0);
        step(1'b1, 32'd4, 1'b0, 1'b0, '0, 32'h0, 1'b0);
        step(1'b1, 32'd8, 1'b0, 1'b0, '0, 32'h0, 1'b0);
        idle();

        // Misaligned, out-of-range, and illegal fetch losing to the loader.
        step(1'b1, 32'h6, 1'b0, 1'b0, '0, 32'h0, 1'b0);
        step(1'b1, 32'd196, 1'b0, 1'b0, '0, 32'h0, 1'b0);
        step(1'b1, 32'd192, 1'b0, 1'b0, '0, 32'h0, 1'b0);
        step(1'b1, 32'h6, 1'b1, 1'b0, AW'(3), 32'h0, 1'b0);
        idle();

        // Loader accesses beyond DEPTH.
        step(1'b0, 32'h0, 1'b1, 1'b0, AW'(50), 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, AW'(55), 32'h5555_5555, 1'b0);
        done_pulse();

        // Contention: 4 fetch wins then one forced loader slot, repeating.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'(4 * (i % 3)), 1'b1, 1'b0, AW'(2), 32'h0, 1'b0);
            check("starve_pattern", 32'(ld_gnt), 32'(i % 5 == 4));
        end
        step(1'b1, 32'd8, 1'b0, 1'b0, '0, 32'h0, 1'b0);
        step(1'b1, 32'd8, 1'b1, 1'b0, AW'(1), 32'h0, 1'b0);
        step(1'b1, 32'd8, 1'b1, 1'b0, AW'(1), 32'h0, 1'b0);
        idle();

        // Write then immediate fetch and read-back of the same word.
        step(1'b0, 32'h0, 1'b1, 1'b1, AW'(5), 32'hDEAD_BEEF, 1'b0);
        step(1'b1, 32'd20, 1'b0, 1'b0, '0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, AW'(5), 32'h0, 1'b0);
        done_pulse();
        idle();

        // Reset asserted while a fetch response is pending.
        step(1'b1, 32'd12, 1'b1, 1'b0, AW'(4), 32'h0, 1'b0);
        @(posedge clk); #1;
        fetch_req = 1'b0; ld_req = 1'b0; ld_we = 1'b0; ld_done = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_fetch_valid", 32'(fetch_valid), 32'h0);
        check("arst_fetch_instr", fetch_instr, NOP);
        check("arst_ld_rvalid", 32'(ld_rvalid), 32'h0);
        check("arst_ld_rdata", ld_rdata, 32'h0);
        check("arst_core_hold", 32'(core_hold), 32'h0);
        sb.delete();
        starve    = 0;
        lock_m    = 1'b0;
        exp_instr = NOP;
        exp_rdata = 32'h0;
        @(posedge clk); #1 rst = 1'b0;
        idle();
        idle();

        // Loader write under contention; with the lock feature the core is held until ld_done.
        for (int i = 0; i < 7; i++)
            step(1'b1, 32'd0, 1'b1, 1'b1, AW'(0), 32'hC0DE_0000 + 32'(i), 1'b0);
        step(1'b1, 32'd0, 1'b0, 1'b0, '0, 32'h0, 1'b0);
        step(1'b1, 32'd0, 1'b0, 1'b0, '0, 32'h0, 1'b1);
        step(1'b1, 32'd0, 1'b0, 1'b0, '0, 32'h0, 1'b0);
        step(1'b1, 32'd4, 1'b0, 1'b0, '0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, AW'(1), 32'h0000_AAAA, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, AW'(1), 32'h0000_BBBB, 1'b1);
        step(1'b1, 32'd4, 1'b0, 1'b0, '0, 32'h0, 1'b0);
        step(1'b1, 32'd4, 1'b0, 1'b0, '0, 32'h0, 1'b1);
        step(1'b1, 32'd4, 1'b0, 1'b0, '0, 32'h0, 1'b0);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
